sync_memory_controller: RTL and testbench

SYNC_MEMORY_CONTROLLER -- requirements
Module: sync_memory_controller

---
 rtl/sync_memory_controller.sv | 147 ++++++++++++++
 tb/tb_sync_memory_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_memory_controller.sv
// Synchronous single-port memory controller behind an asynchronous-style CPU strobe bus.
// A request is accepted in IDLE, optionally stretched by WAIT_STATES cycles, performed in a
// single ACCESS cycle, and then held in RELEASE until the CPU drops its strobes.
module sync_memory_controller #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PROTECT_TOP = 0
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  input  logic                  nchip_enable,
  input  logic                  nread_enable,
  input  logic                  nwrite_enable,
  output logic                  ready,
  output logic                  fault
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);
  // One extra bit so PROTECT_TOP may equal the full depth.
  localparam logic [ADDR_WIDTH:0] ProtTop = (ADDR_WIDTH + 1)'(PROTECT_TOP);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StRelease} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_oe_q, data_oe_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic req_rd, req_wr, req_bad, wr_protected;

  assign req_rd       = !nchip_enable && !nread_enable && nwrite_enable;
  assign req_wr       = !nchip_enable && nread_enable && !nwrite_enable;
  assign req_bad      = !nchip_enable && !nread_enable && !nwrite_enable;
  assign wr_protected = ({1'b0, addr_q} < ProtTop);

  // Next-state, latched request and registered output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = 1'b1;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    ready_d    = 1'b0;
    fault_d    = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // armed_q blocks acceptance on the first edge after reset release.
        if (armed_q) begin
          if (req_rd || req_wr) begin
            addr_d  = address;
            wdata_d = data_in;
            we_d    = req_wr;
            if (WAIT_STATES == 0) begin
              state_d = StAccess;
            end else begin
              state_d = StWait;
              cnt_d   = WaitInit;
            end
          end else if (req_bad) begin
            fault_d = 1'b1;
            state_d = StRelease;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: begin
        state_d = StRelease;
        ready_d = 1'b1;
        if (we_q) begin
          fault_d = wr_protected;
          mem_we  = !wr_protected;
        end else begin
          data_out_d = mem_q[addr_q];
          data_oe_d  = 1'b1;
        end
      end
      StRelease: begin
        // Wait for the strobes to drop so a held request is not repeated.
        if (nchip_enable || (nread_enable && nwrite_enable)) begin
          state_d   = StIdle;
          data_oe_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[addr_q] <= wdata_q;
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign ready    = ready_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_sync_memory_controller.sv
// Two controllers share one CPU bus: A (16-bit address, 8-bit data, no wait states, low 256
// words protected) and B (4-bit address, 16-bit data, 3 wait states, no protection).
module tb_sync_memory_controller;

  logic        clock = 1'b0;
  logic        nreset;
  logic [15:0] address;
  logic [15:0] data_in;
  logic        nce, nre, nwe;

  logic [7:0]  a_dout;
  logic        a_oe, a_ready, a_fault;
  logic [15:0] b_dout;
  logic        b_oe, b_ready, b_fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: plain arrays of what each memory must hold.
  logic [7:0]  mem_a [int];
  logic [15:0] mem_b [16];
  bit          b_valid [16];
  logic [7:0]  a_last;
  bit          a_last_known;
  logic [15:0] b_last;
  bit          b_last_known;

  localparam int BWait = 3;

  always #5 clock = ~clock;

  sync_memory_controller #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0), .PROTECT_TOP(32'h0100)
  ) dut_a (
    .clock(clock), .nreset(nreset), .address(address), .data_in(data_in[7:0]),
    .data_out(a_dout), .data_oe(a_oe), .nchip_enable(nce), .nread_enable(nre),
    .nwrite_enable(nwe), .ready(a_ready), .fault(a_fault)
  );

  sync_memory_controller #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .WAIT_STATES(BWait), .PROTECT_TOP(0)
  ) dut_b (
    .clock(clock), .nreset(nreset), .address(address[3:0]), .data_in(data_in),
    .data_out(b_dout), .data_oe(b_oe), .nchip_enable(nce), .nread_enable(nre),
    .nwrite_enable(nwe), .ready(b_ready), .fault(b_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a_dout"}, 32'(a_dout), 0);
    check({tag, " a_oe"}, 32'(a_oe), 0);
    check({tag, " a_ready"}, 32'(a_ready), 0);
    check({tag, " a_fault"}, 32'(a_fault), 0);
    check({tag, " b_dout"}, 32'(b_dout), 0);
    check({tag, " b_oe"}, 32'(b_oe), 0);
    check({tag, " b_ready"}, 32'(b_ready), 0);
    check({tag, " b_fault"}, 32'(b_fault), 0);
  endtask

  task automatic reset_model_outputs();
    a_last = '0; a_last_known = 1'b1;
    b_last = '0; b_last_known = 1'b1;
  endtask

  // One bus access, strobes held 10 edges past acceptance, then released.
  task automatic do_access(input bit we, input logic [15:0] addr, input logic [15:0] din,
                           input bit after_reset);
    int lead, a_rk, b_rk, a_rc, b_rc, a_fc, b_fc, a_fk;
    bit a_prot, a_known, b_known, a_oe_rdy, b_oe_rdy, a_oe_held, b_oe_held;
    logic [7:0] a_exp, a_rd;
    logic [15:0] b_exp, b_rd;
    int a_idx, b_idx;
    a_idx = int'(addr);
    b_idx = int'(addr[3:0]);
    a_prot = we && (addr < 16'h0100);
    a_known = mem_a.exists(a_idx);
    a_exp = a_known ? mem_a[a_idx] : 8'h00;
    b_known = b_valid[b_idx];
    b_exp = mem_b[b_idx];
    a_rk = -1; b_rk = -1; a_rc = 0; b_rc = 0; a_fc = 0; b_fc = 0; a_fk = -1;
    a_rd = '0; b_rd = '0; a_oe_rdy = 0; b_oe_rdy = 0; a_oe_held = 0; b_oe_held = 0;
    @(negedge clock);
    address = addr; data_in = din; nce = 1'b0; nre = we; nwe = !we;
    lead = 0;
    if (after_reset) begin
      nreset = 1'b0;
      #1 check_all_zero("reset_with_request");
      reset_model_outputs();
      @(negedge clock);
      nreset = 1'b1;
      lead = 1;
    end
    for (int k = 0; k < 12 + lead; k++) begin
      @(posedge clock);
      #1;
      if (k == lead) begin
        address = 16'($urandom);
        data_in = 16'($urandom);
      end
      if (a_ready) begin a_rc++; if (a_rk < 0) begin a_rk = k; a_rd = a_dout; a_oe_rdy = a_oe; end end
      if (b_ready) begin b_rc++; if (b_rk < 0) begin b_rk = k; b_rd = b_dout; b_oe_rdy = b_oe; end end
      if (a_fault) begin a_fc++; a_fk = k; end
      if (b_fault) b_fc++;
      if (k == 9 + lead) begin
        a_oe_held = a_oe; b_oe_held = b_oe;
        nce = 1'b1; nre = 1'b1; nwe = 1'b1;
      end
    end
    check("a_ready_latency", 32'(a_rk), 32'(lead + 1));
    check("b_ready_latency", 32'(b_rk), 32'(lead + BWait + 1));
    check("a_ready_count", 32'(a_rc), 1);
    check("b_ready_count", 32'(b_rc), 1);
    check("a_fault_count", 32'(a_fc), a_prot ? 1 : 0);
    if (a_prot) check("a_fault_with_ready", 32'(a_fk), 32'(a_rk));
    check("b_fault_count", 32'(b_fc), 0);
    check("a_oe_at_ready", 32'(a_oe_rdy), we ? 0 : 1);
    check("b_oe_at_ready", 32'(b_oe_rdy), we ? 0 : 1);
    check("a_oe_while_held", 32'(a_oe_held), we ? 0 : 1);
    check("b_oe_while_held", 32'(b_oe_held), we ? 0 : 1);
    check("a_oe_after_release", 32'(a_oe), 0);
    check("b_oe_after_release", 32'(b_oe), 0);
    if (!we) begin
      if (a_known) check("a_read_data", 32'(a_rd), 32'(a_exp));
      if (b_known) check("b_read_data", 32'(b_rd), 32'(b_exp));
      a_last = a_exp; a_last_known = a_known;
      b_last = b_exp; b_last_known = b_known;
    end else begin
      if (!a_prot) mem_a[a_idx] = din[7:0];
      mem_b[b_idx] = din;
      b_valid[b_idx] = 1'b1;
    end
    if (a_last_known) check("a_dout_hold", 32'(a_dout), 32'(a_last));
    if (b_last_known) check("b_dout_hold", 32'(b_dout), 32'(b_last));
  endtask

  // Both strobes low with chip enabled: a lone fault pulse and no access.
  task automatic illegal();
    int a_fc, b_fc, a_rc, b_rc, a_fk, b_fk;
    a_fc = 0; b_fc = 0; a_rc = 0; b_rc = 0; a_fk = -1; b_fk = -1;
    @(negedge clock);
    address = 16'($urandom); data_in = 16'($urandom);
    nce = 1'b0; nre = 1'b0; nwe = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      if (a_fault) begin a_fc++; if (a_fk < 0) a_fk = k; end
      if (b_fault) begin b_fc++; if (b_fk < 0) b_fk = k; end
      if (a_ready) a_rc++;
      if (b_ready) b_rc++;
      if (k == 3) begin nce = 1'b1; nre = 1'b1; nwe = 1'b1; end
    end
    check("illegal_a_fault_count", 32'(a_fc), 1);
    check("illegal_b_fault_count", 32'(b_fc), 1);
    check("illegal_a_fault_edge", 32'(a_fk), 0);
    check("illegal_b_fault_edge", 32'(b_fk), 0);
    check("illegal_a_no_ready", 32'(a_rc), 0);
    check("illegal_b_no_ready", 32'(b_rc), 0);
  endtask

  // Start a write and pull reset during B's wait states; A has already committed.
  task automatic abort_write(input logic [15:0] addr, input logic [15:0] din);
    @(negedge clock);
    address = addr; data_in = din; nce = 1'b0; nre = 1'b1; nwe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
    end
    nreset = 1'b0;
    #1 check_all_zero("abort_reset");
    if (!(addr < 16'h0100)) mem_a[int'(addr)] = din[7:0];
    reset_model_outputs();
    nce = 1'b1; nre = 1'b1; nwe = 1'b1;
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    nreset = 1'b0;
    nce = 1'b1; nre = 1'b1; nwe = 1'b1;
    address = '0; data_in = '0;
    for (int i = 0; i < 16; i++) begin mem_b[i] = '0; b_valid[i] = 1'b0; end
    reset_model_outputs();
    #3 check_all_zero("reset");
    @(negedge clock);
    nreset = 1'b1;
    repeat (2) @(negedge clock);

    // Basic write then read.
    do_access(1'b1, 16'h1234, 16'h00A5, 1'b0);
    do_access(1'b0, 16'h1234, 16'h0000, 1'b0);

    // Protection boundary on A.
    do_access(1'b1, 16'h00FF, 16'h005A, 1'b0);
    do_access(1'b0, 16'h00FF, 16'h0000, 1'b0);
    n_tests++;
    assert (a_dout !== 8'h5A) else begin
      n_fail++;
      $error("FAIL protected_unchanged: observed %0h expected not 5a", a_dout);
    end
    do_access(1'b1, 16'h0100, 16'h00C3, 1'b0);
    do_access(1'b0, 16'h0100, 16'h0000, 1'b0);

    // Illegal strobes, then a normal request is still served.
    illegal();
    do_access(1'b0, 16'h1234, 16'h0000, 1'b0);

    // Extreme addresses of the narrow memory do not alias.
    do_access(1'b1, 16'h000F, 16'hBEEF, 1'b0);
    do_access(1'b1, 16'h0000, 16'h1234, 1'b0);
    do_access(1'b0, 16'h000F, 16'h0000, 1'b0);
    do_access(1'b0, 16'h0000, 16'h0000, 1'b0);

    // Reset in the wait window drops B's pending write.
    abort_write(16'h1230, 16'h7E7E);
    do_access(1'b0, 16'h1230, 16'h0000, 1'b0);

    // Request pending across reset release; memory retained.
    do_access(1'b0, 16'h1234, 16'h0000, 1'b1);

    // Random traffic over a small address pool straddling the protection boundary.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [7:0]  hi;
      int          sel;
      sel = int'($urandom_range(0, 2));
      hi = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : 8'hAB;
      ra = {hi, 4'h0, 4'($urandom_range(0, 15))};
      do_access(1'($urandom_range(0, 1)), ra, 16'($urandom), 1'b0);
      if ($urandom_range(0, 9) == 0) illegal();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
